mine_game_ctrl: RTL



---
 rtl/mine_pkg.sv | 31 +++
 rtl/reveal_expand.sv | 29 ++
 rtl/mine_game_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mine_pkg.sv
// Shared game-state encoding, direction codes and helpers for the minesweeper controller.
package mine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        FLOOD = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } gameStateT;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int BOMB_COUNT = 9;

    // Widest board the one-hot helper accepts; narrower vectors are zero-extended.
    localparam int MAX_CELLS = 256;

    function automatic logic isOneHot(input logic [MAX_CELLS-1:0] v);
        logic [8:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            ones = ones + 9'(v[i]);
        end
        return (ones == 9'd1);
    endfunction

endpackage

// File: rtl/reveal_expand.sv
// Maps a seed mask to the union of the 8-neighbourhoods of its set cells.
module reveal_expand #(
    parameter int GRID_SIZE = 3
) (
    input  logic [GRID_SIZE*GRID_SIZE-1:0] seed_i,
    output logic [GRID_SIZE*GRID_SIZE-1:0] expanded_o
);

    // Row/column bounds are checked explicitly so neighbours never wrap across rows.
    always_comb begin
        expanded_o = '0;
        for (int r = 0; r < GRID_SIZE; r++) begin
            for (int c = 0; c < GRID_SIZE; c++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) &&
                            (r + dr >= 0) && (r + dr < GRID_SIZE) &&
                            (c + dc >= 0) && (c + dc < GRID_SIZE)) begin
                            if (seed_i[(r + dr) * GRID_SIZE + (c + dc)]) begin
                                expanded_o[r * GRID_SIZE + c] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game controller: owns the bomb/reveal/flag/cursor grids and sequences
// reveals, flag toggles, cursor moves, flood-reveal and win/loss detection.
module mine_game_ctrl
    import mine_pkg::*;
#(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]          bombMap,
    input  logic                                    btnMove,
    input  logic [1:0]                              btnDir,
    input  logic                                    btnReveal,
    input  logic                                    btnFlag,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]          nextCursorGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          bombGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          revealGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          cursorGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          flagGrid,
    output logic                                    move,
    output logic [1:0]                              dir,
    output logic [2:0]                              gameState
);

    localparam int N = GRID_SIZE * GRID_SIZE;
    localparam logic [N-1:0] CURSOR_HOME = {1'b1, {(N-1){1'b0}}};

    gameStateT    state_q;
    logic [N-1:0] bombGrid_q;
    logic [N-1:0] revealGrid_q;
    logic [N-1:0] flagGrid_q;
    logic [N-1:0] cursorGrid_q;

    logic [N-1:0] zeroMask;
    logic [N-1:0] floodRing;
    logic [N-1:0] floodAdd;
    logic         cursorFlagged;
    logic         cursorRevealed;
    logic         cursorBomb;
    logic         cursorZero;
    logic         allCleared;
    logic         cursorStepValid;

    always_comb begin
        zeroMask = '0;
        for (int i = 0; i < N; i++) begin
            zeroMask[i] = (states[i*STATE_SIZE +: STATE_SIZE] == '0);
        end
    end

    reveal_expand #(
        .GRID_SIZE (GRID_SIZE)
    ) u_reveal_expand (
        .seed_i     (revealGrid_q & zeroMask),
        .expanded_o (floodRing)
    );

    assign floodAdd        = floodRing & ~revealGrid_q & ~bombGrid_q & ~flagGrid_q;
    assign cursorFlagged   = |(cursorGrid_q & flagGrid_q);
    assign cursorRevealed  = |(cursorGrid_q & revealGrid_q);
    assign cursorBomb      = |(cursorGrid_q & bombGrid_q);
    assign cursorZero      = |(cursorGrid_q & zeroMask);
    assign allCleared      = &(revealGrid_q | bombGrid_q);
    // A non-one-hot next cursor means the move ran into a wall, so the cursor holds.
    assign cursorStepValid = isOneHot(MAX_CELLS'(nextCursorGrid));

    // The move request to the board only fires when no higher-priority button is pressed.
    assign move = (state_q == PLAY) && btnMove && !btnReveal && !btnFlag;
    assign dir  = move ? btnDir : DIR_RIGHT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bombGrid_q   <= '0;
            revealGrid_q <= '0;
            flagGrid_q   <= '0;
            cursorGrid_q <= CURSOR_HOME;
        end else if (start) begin
            state_q      <= PLAY;
            bombGrid_q   <= bombMap;
            revealGrid_q <= '0;
            flagGrid_q   <= '0;
            cursorGrid_q <= CURSOR_HOME;
        end else begin
            case (state_q)
                PLAY: begin
                    if (allCleared) begin
                        state_q <= WON;
                    end else if (btnReveal) begin
                        if (!cursorFlagged && !cursorRevealed) begin
                            if (cursorBomb) begin
                                revealGrid_q <= revealGrid_q | bombGrid_q;
                                state_q      <= LOST;
                            end else begin
                                revealGrid_q <= revealGrid_q | cursorGrid_q;
                                if (cursorZero) begin
                                    state_q <= FLOOD;
                                end
                            end
                        end
                    end else if (btnFlag) begin
                        if (!cursorRevealed) begin
                            flagGrid_q <= flagGrid_q ^ cursorGrid_q;
                        end
                    end else if (move && cursorStepValid) begin
                        cursorGrid_q <= nextCursorGrid;
                    end
                end
                // One neighbour ring per cycle until the flood stops growing.
                FLOOD: begin
                    if (allCleared) begin
                        state_q <= WON;
                    end else if (floodAdd == '0) begin
                        state_q <= PLAY;
                    end else begin
                        revealGrid_q <= revealGrid_q | floodAdd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bombGrid   = bombGrid_q;
    assign revealGrid = revealGrid_q;
    assign flagGrid   = flagGrid_q;
    assign cursorGrid = cursorGrid_q;
    assign gameState  = state_q;

endmodule
